// File: rtl/key_load_ctrl.sv
// -----------------------------------------------------------------------------
// key_load_ctrl
//
// Loads a KEY_W-bit key serially into a holding register that drives the key
// inputs of a locked netlist. The key arrives MSB first on a valid/ready bit
// stream and is followed by one even-parity bit. A key whose parity checks is
// exposed on key_out with key_valid. A key whose parity fails raises a one-cycle
// err pulse. After MAX_FAIL consecutive failures the controller locks, and only
// reset releases it.
//
// Handshake: sin_ready is high only in SHIFT. A bit moves on a rising edge of C
// when both sin_valid and sin_ready are high at that edge. The source may hold
// sin_valid low for any number of cycles. sin_ready never depends
// combinationally on sin_valid.
//
// Ports
//   C          in   clock; all state updates on its rising edge
//   R          in   synchronous active-low reset
//   start      in   level request to load (or reload) a key
//   abort      in   cancel an in-progress load (SHIFT or CHECK)
//   sin_valid  in   serial bit valid
//   sin_data   in   serial bit: KEY_W key bits MSB first, then parity
//   sin_ready  out  controller accepts a serial bit (SHIFT only)
//   key_out    out  verified key while key_valid, otherwise all zeros
//   key_valid  out  key_out holds a verified key (DONE)
//   busy       out  load in progress (SHIFT or CHECK)
//   err        out  one-cycle pulse on a parity failure
//   locked     out  sticky lockout indicator (LOCK)
//   dbg_state  out  current FSM state, for observation only
//
// Every output is a flop. Its next value is decoded from the next-state logic,
// so the outputs track the state register without any input-to-output
// combinational path.
// -----------------------------------------------------------------------------
module key_load_ctrl #(
  parameter int KEY_W    = 64,
  parameter int MAX_FAIL = 3
) (
  input  logic             C,
  input  logic             R,
  input  logic             start,
  input  logic             abort,
  input  logic             sin_valid,
  input  logic             sin_data,
  output logic             sin_ready,
  output logic [KEY_W-1:0] key_out,
  output logic             key_valid,
  output logic             busy,
  output logic             err,
  output logic             locked,
  output logic [2:0]       dbg_state
);

  // Bit counter must reach KEY_W; fail counter must reach MAX_FAIL.
  localparam int CW = $clog2(KEY_W + 1);
  localparam int FW = $clog2(MAX_FAIL + 1);

  localparam logic [CW-1:0] CNT_FULL = CW'(KEY_W);
  localparam logic [FW-1:0] FAIL_LIM = FW'(MAX_FAIL);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SHIFT = 3'd1,
    CHECK = 3'd2,
    DONE  = 3'd3,
    LOCK  = 3'd4
  } state_t;

  state_t           state, state_next;
  logic [KEY_W-1:0] sreg, sreg_next;
  logic [CW-1:0]    cnt, cnt_next;
  logic             par, par_next;
  logic [FW-1:0]    fails, fails_next;
  logic             err_next;

  logic             xfer;
  logic             check_ok;
  logic [FW-1:0]    fail_inc;

  // sin_ready is the registered copy of (state == SHIFT), so it is safe to
  // qualify transfers with it.
  assign xfer     = sin_valid & sin_ready;

  // Even parity: key bits XOR parity bit must reduce to zero.
  assign check_ok = ((^sreg) ^ par) == 1'b0;

  // Saturating increment. The counter never wraps, even though LOCK is
  // reached before saturation matters.
  assign fail_inc = (fails == FAIL_LIM) ? fails : fails + 1'b1;

  assign dbg_state = state;

  // ---------------------------------------------------------------------------
  // Next-state and datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    sreg_next  = sreg;
    cnt_next   = cnt;
    par_next   = par;
    fails_next = fails;
    err_next   = 1'b0;

    case (state)
      IDLE: begin
        // abort is ignored in IDLE, but a start raised together with abort
        // does not launch a load.
        if (start && !abort) begin
          state_next = SHIFT;
          sreg_next  = '0;
          cnt_next   = '0;
          par_next   = 1'b0;
        end
      end

      SHIFT: begin
        // abort wins over a simultaneous transfer; start is ignored here.
        if (abort) begin
          state_next = IDLE;
          sreg_next  = '0;
          cnt_next   = '0;
          par_next   = 1'b0;
        end else if (xfer) begin
          if (cnt == CNT_FULL) begin
            // All key bits are in. This transfer is the parity bit.
            par_next   = sin_data;
            state_next = CHECK;
          end else begin
            sreg_next = {sreg[KEY_W-2:0], sin_data};
            cnt_next  = cnt + 1'b1;
          end
        end
      end

      CHECK: begin
        if (abort) begin
          // A cancelled check is not a failure: no err, and fails are kept.
          state_next = IDLE;
          sreg_next  = '0;
        end else if (check_ok) begin
          state_next = DONE;
          fails_next = '0;
        end else begin
          err_next   = 1'b1;
          fails_next = fail_inc;
          sreg_next  = '0;
          state_next = (fail_inc == FAIL_LIM) ? LOCK : IDLE;
        end
      end

      DONE: begin
        // Reload. The old key is dropped at this same edge.
        if (start) begin
          state_next = SHIFT;
          sreg_next  = '0;
          cnt_next   = '0;
          par_next   = 1'b0;
        end
      end

      LOCK: begin
        // Terminal until reset. All inputs are ignored.
        state_next = LOCK;
      end

      default: begin
        state_next = IDLE;
        sreg_next  = '0;
        cnt_next   = '0;
        par_next   = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, datapath and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge C) begin
    if (!R) begin
      state     <= IDLE;
      sreg      <= '0;
      cnt       <= '0;
      par       <= 1'b0;
      fails     <= '0;
      sin_ready <= 1'b0;
      key_out   <= '0;
      key_valid <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
      locked    <= 1'b0;
    end else begin
      state     <= state_next;
      sreg      <= sreg_next;
      cnt       <= cnt_next;
      par       <= par_next;
      fails     <= fails_next;
      sin_ready <= (state_next == SHIFT);
      busy      <= (state_next == SHIFT) || (state_next == CHECK);
      key_valid <= (state_next == DONE);
      // Only a verified key ever reaches the netlist. Partial shifts stay hidden.
      key_out   <= (state_next == DONE) ? sreg_next : '0;
      err       <= err_next;
      locked    <= (state_next == LOCK);
    end
  end

endmodule

// File: tb/tb_key_load_ctrl.sv
// -----------------------------------------------------------------------------
// tb_key_load_ctrl
//
// Self-checking bench for key_load_ctrl with KEY_W=8 and MAX_FAIL=3.
//
// Inputs are driven on the falling edge of C, and outputs are sampled on the
// falling edge. Each completed load pushes its expected result,
// {locked, err, key_valid, key_out}, onto exp_q. That entry is popped and
// compared on the cycle after CHECK.
// -----------------------------------------------------------------------------
module tb_key_load_ctrl;

  localparam int KEY_W    = 8;
  localparam int MAX_FAIL = 3;
  localparam int RW       = KEY_W + 3;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SHIFT = 3'd1;
  localparam logic [2:0] S_CHECK = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_LOCK  = 3'd4;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic             C = 1'b0;
  logic             R = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             sin_valid = 1'b0;
  logic             sin_data = 1'b0;
  logic             sin_ready;
  logic [KEY_W-1:0] key_out;
  logic             key_valid;
  logic             busy;
  logic             err;
  logic             locked;
  logic [2:0]       dbg_state;

  always #5 C = ~C;

  key_load_ctrl #(.KEY_W(KEY_W), .MAX_FAIL(MAX_FAIL)) dut (
    .C         (C),
    .R         (R),
    .start     (start),
    .abort     (abort),
    .sin_valid (sin_valid),
    .sin_data  (sin_data),
    .sin_ready (sin_ready),
    .key_out   (key_out),
    .key_valid (key_valid),
    .busy      (busy),
    .err       (err),
    .locked    (locked),
    .dbg_state (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int              total = 0;
  int              bad = 0;
  int              fail_model = 0;
  logic [RW-1:0]   exp_q[$];

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input logic [KEY_W-1:0] key, input logic good);
    if (good) begin
      fail_model = 0;
      exp_q.push_back({1'b0, 1'b0, 1'b1, key});
    end else begin
      if (fail_model < MAX_FAIL) fail_model++;
      exp_q.push_back({(fail_model >= MAX_FAIL), 1'b1, 1'b0, {KEY_W{1'b0}}});
    end
  endtask

  task automatic check_result(input string tag);
    logic [RW-1:0] e;
    if (exp_q.size() == 0) begin
      check_val({tag, "_q_empty"}, 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    check_val(tag, {locked, err, key_valid, key_out}, e);
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic idle_outputs(input string tag);
    check_val({tag, "_kv"},   key_valid, 1'b0);
    check_val({tag, "_key"},  key_out,   '0);
    check_val({tag, "_busy"}, busy,      1'b0);
    check_val({tag, "_rdy"},  sin_ready, 1'b0);
    check_val({tag, "_err"},  err,       1'b0);
  endtask

  task automatic do_reset(input string tag);
    R = 1'b0; start = 1'b0; abort = 1'b0; sin_valid = 1'b0; sin_data = 1'b0;
    repeat (2) @(negedge C);
    idle_outputs(tag);
    check_val({tag, "_lock"},  locked,    1'b0);
    check_val({tag, "_state"}, dbg_state, S_IDLE);
    R = 1'b1;
    fail_model = 0;
    exp_q.delete();
  endtask

  task automatic start_load(input string tag);
    start = 1'b1;
    @(negedge C);
    start = 1'b0;
    check_val({tag, "_st_busy"}, busy,      1'b1);
    check_val({tag, "_st_rdy"},  sin_ready, 1'b1);
    check_val({tag, "_st_kv"},   key_valid, 1'b0);
    check_val({tag, "_st_key"},  key_out,   '0);
  endtask

  task automatic send_bit(input logic b);
    int n;
    n = 0;
    while (!sin_ready && n < 20) begin
      @(negedge C);
      n++;
    end
    if (!sin_ready) begin
      check_val("ready_wait", sin_ready, 1'b1);
      return;
    end
    sin_valid = 1'b1;
    sin_data  = b;
    @(negedge C);
    sin_valid = 1'b0;
  endtask

  // Full load. The stall is inserted after bit number stall_at (0 = MSB), and
  // start is held high during the stall to show it is ignored in SHIFT.
  task automatic load_key(input logic [KEY_W-1:0] key, input logic good,
                          input int stall_at, input int stall_len,
                          input string tag);
    start_load(tag);
    for (int i = KEY_W - 1; i >= 0; i--) begin
      send_bit(key[i]);
      check_val({tag, "_part_key"}, key_out, '0);
      if ((KEY_W - 1 - i) == stall_at) begin
        for (int s = 0; s < stall_len; s++) begin
          start = 1'b1;
          @(negedge C);
          check_val({tag, "_stall_busy"},  busy,      1'b1);
          check_val({tag, "_stall_state"}, dbg_state, S_SHIFT);
        end
        start = 1'b0;
      end
    end
    push_exp(key, good);
    send_bit(good ? ^key : ~(^key));
    check_val({tag, "_in_check"}, dbg_state, S_CHECK);
    check_val({tag, "_chk_busy"}, busy,      1'b1);
    check_val({tag, "_chk_rdy"},  sin_ready, 1'b0);
    @(negedge C);
    check_result(tag);
    @(negedge C);
    check_val({tag, "_err_once"}, err, 1'b0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [KEY_W-1:0] k;

    do_reset("rst0");

    // Basic load, then DONE holds with start low and ignores abort.
    load_key(8'hB2, 1'b1, -1, 0, "basic");
    abort = 1'b1;
    repeat (3) @(negedge C);
    abort = 1'b0;
    check_val("done_hold_state", dbg_state, S_DONE);
    check_val("done_hold_kv",    key_valid, 1'b1);
    check_val("done_hold_key",   key_out,   8'hB2);

    // Reload from DONE.
    load_key(8'h3C, 1'b1, -1, 0, "reload");
    check_val("reload_key", key_out, 8'h3C);

    // Parity failure.
    load_key(8'hB2, 1'b0, -1, 0, "parfail");
    check_val("parfail_state", dbg_state, S_IDLE);
    idle_outputs("parfail_after");

    // Abort together with the transfer of bit 6.
    k = 8'hB2;
    start_load("abt");
    for (int i = KEY_W - 1; i >= 2; i--) send_bit(k[i]);
    sin_valid = 1'b1; sin_data = k[1]; abort = 1'b1;
    @(negedge C);
    sin_valid = 1'b0; abort = 1'b0;
    check_val("abt_state", dbg_state, S_IDLE);
    idle_outputs("abt");
    @(negedge C);
    check_val("abt_err_late", err, 1'b0);

    // Abort while in CHECK with a bad parity bit: no err.
    k = 8'h5A;
    start_load("abtchk");
    for (int i = KEY_W - 1; i >= 0; i--) send_bit(k[i]);
    sin_valid = 1'b1; sin_data = ~(^k);
    @(negedge C);
    sin_valid = 1'b0;
    check_val("abtchk_in_check", dbg_state, S_CHECK);
    abort = 1'b1;
    @(negedge C);
    abort = 1'b0;
    check_val("abtchk_state", dbg_state, S_IDLE);
    idle_outputs("abtchk");

    // Second real failure. The aborts above must not have counted.
    load_key(8'hB2, 1'b0, -1, 0, "fail2");
    check_val("fail2_state", dbg_state, S_IDLE);

    // Stalled good load passes and clears the fail count.
    load_key(8'hB2, 1'b1, 3, 5, "stall");

    // Random good loads with random stalls.
    for (int n = 0; n < 4; n++) begin
      k = KEY_W'($urandom_range(0, 255));
      load_key(k, 1'b1, $urandom_range(0, KEY_W - 1), $urandom_range(0, 3),
               "rand");
    end

    // Lockout after three consecutive failures.
    for (int n = 0; n < MAX_FAIL; n++) begin
      k = KEY_W'($urandom_range(0, 255));
      load_key(k, 1'b0, -1, 0, "lockseq");
    end
    check_val("lock_state", dbg_state, S_LOCK);
    start = 1'b1; sin_valid = 1'b1; sin_data = 1'b1;
    for (int n = 0; n < 4; n++) begin
      abort = n[0];
      @(negedge C);
      check_val("lock_hold_state", dbg_state, S_LOCK);
      check_val("lock_hold_lock",  locked,    1'b1);
      idle_outputs("lock_hold");
    end
    start = 1'b0; sin_valid = 1'b0; abort = 1'b0;

    // Only reset leaves LOCK, and a good load works afterwards.
    do_reset("rst_lock");
    load_key(8'hB2, 1'b1, -1, 0, "post_rst");

    check_val("q_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
